// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the lab03 instruction sequencer and the control unit
// that consumes its issued instructions.
package seq_pkg;

  typedef enum logic [2:0] {
    OP_MV   = 3'd0,
    OP_MVI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_HALT = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_IMM_CAP,
    S_ISSUE,
    S_WAIT,
    S_HALTED
  } seq_state_t;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 13;
  localparam int unsigned RX_MSB = 12;
  localparam int unsigned RX_LSB = 10;
  localparam int unsigned RY_MSB = 9;
  localparam int unsigned RY_LSB = 7;

  function automatic logic [2:0] op_field(input logic [15:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [2:0] rx_field(input logic [15:0] w);
    return w[RX_MSB:RX_LSB];
  endfunction

  function automatic logic [2:0] ry_field(input logic [15:0] w);
    return w[RY_MSB:RY_LSB];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Issue handshake between the sequencer (master) and the control unit (slave).
interface instr_sequencer_if;
  logic [15:0] instruction;
  logic [15:0] imm_data;
  logic        run;
  logic        done;

  modport master (output instruction, output imm_data, output run, input done);
  modport slave  (input instruction, input imm_data, input run, output done);
endinterface

// File: rtl/instr_sequencer_prog_ram.sv
// Program RAM: one synchronous write port, one synchronous read port (1-cycle latency).
module prog_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches program words, issues each with a run strobe,
// waits for done, and traps on halt or a done watchdog timeout.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                load_we,
  input  logic [AW-1:0]       load_addr,
  input  logic [15:0]         load_data,
  instr_sequencer_if.master   ctrl,
  output logic [AW-1:0]       pc,
  output logic                busy,
  output logic                halted,
  output logic                timeout_err
);

  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  seq_state_t      state, next_state;
  logic [15:0]     ir;
  logic [15:0]     imm;
  logic [15:0]     rd_data;
  logic [WDW-1:0]  wd;
  logic            idle_like;
  logic            ram_we;

  assign idle_like = (state == S_IDLE) || (state == S_HALTED);
  assign ram_we    = load_we && idle_like;

  // Reading at pc every cycle covers both FETCH and IMM; the data is only
  // consumed in DECODE and IMM_CAP.
  prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_HALTED: if (start) next_state = S_FETCH;
      S_FETCH:          next_state = S_DECODE;
      S_DECODE: begin
        if (op_field(rd_data) == OP_HALT)     next_state = S_HALTED;
        else if (op_field(rd_data) == OP_MVI) next_state = S_IMM;
        else                                  next_state = S_ISSUE;
      end
      S_IMM:            next_state = S_IMM_CAP;
      S_IMM_CAP:        next_state = S_ISSUE;
      S_ISSUE:          next_state = ctrl.done ? S_FETCH : S_WAIT;
      S_WAIT: begin
        if (ctrl.done)          next_state = S_FETCH;
        else if (wd == WD_LAST) next_state = S_HALTED;
      end
      default:          next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= '0;
      ir          <= '0;
      imm         <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc          <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_DECODE: begin
          ir <= rd_data;
          pc <= pc + AW'(1);
        end
        S_IMM_CAP: begin
          imm <= rd_data;
          pc  <= pc + AW'(1);
        end
        S_ISSUE: wd <= '0;
        S_WAIT: begin
          if (!ctrl.done) begin
            if (wd == WD_LAST) timeout_err <= 1'b1;
            else               wd <= wd + WDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ctrl.instruction = ir;
  assign ctrl.imm_data    = imm;
  assign ctrl.run         = (state == S_ISSUE);
  assign busy             = !idle_like;
  assign halted           = (state == S_HALTED);

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction sequencer for the lab03 simple processor. It holds a small program RAM, fetches 16-bit instruction words (plus the immediate word for `mvi`), and presents each instruction with a one-cycle `run` strobe to the processor control unit. It then waits for the control unit's `done` pulse before fetching the next instruction. It sits between the board/testbench loader and the control unit, and owns the program counter and program halt.

## Interface
Parameters:
- DEPTH, 32, program RAM words (power of two)
- AW, $clog2(DEPTH), address width
- TIMEOUT, 16, max cycles spent waiting for `done` before the error trap

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin execution at address 0; honoured only in IDLE or HALTED
- load_we  in  1  program RAM write enable; honoured only in IDLE or HALTED, dropped otherwise
- load_addr  in  AW  program RAM write address
- load_data  in  16  program RAM write data
- done  in  1  single-cycle completion pulse from the control unit
- instruction  out  16  current instruction word, held stable from ISSUE until the next DECODE
- imm_data  out  16  immediate word for `mvi`, valid alongside `instruction`
- run  out  1  one-cycle issue strobe
- pc  out  AW  address of the next word to fetch
- busy  out  1  high in every state except IDLE and HALTED
- halted  out  1  high in HALTED
- timeout_err  out  1  sticky; set on watchdog expiry, cleared by `start` or reset

## Operation
- Instruction format: [15:13] opcode, [12:10] Rx, [9:7] Ry, [6:0] unused. Opcodes:
  - 000 mv
  - 001 mvi
  - 010 add
  - 011 sub
  - 111 halt, consumed by the sequencer and never issued
  - 100–110 issued unchanged as opaque words
- State machine: IDLE, FETCH, DECODE, IMM, IMM_CAP, ISSUE, WAIT, HALTED.
- IDLE/HALTED + start: pc←0, timeout_err←0, go to FETCH.
- FETCH: RAM read address = pc. Go to DECODE.
- DECODE: ir←RAM data, pc←pc+1. Next state by opcode:
  - halt → HALTED
  - mvi → IMM
  - anything else → ISSUE
- IMM: read address = pc. Go to IMM_CAP.
- IMM_CAP: imm←RAM data, pc←pc+1. Go to ISSUE.
- ISSUE: run=1 for exactly this cycle. If done=1 here, go to FETCH; otherwise go to WAIT.
- WAIT: watchdog counter increments each cycle.
  - done=1 → FETCH.
  - Counter reaches TIMEOUT-1 without done → timeout_err←1, go to HALTED.
- `done` is ignored outside ISSUE and WAIT.
- pc arithmetic is modulo DEPTH. Increment from DEPTH-1 wraps to 0. An `mvi` at DEPTH-1 takes its immediate from address 0.
- `imm_data` keeps its last value for non-mvi instructions.
- Simultaneous load_we and start in IDLE: the write completes at that edge, and the first fetch reads the new contents.
- Asynchronous reset mid-operation: returns to IDLE immediately and all outputs take reset values. RAM contents are not cleared.
- Reset values: state IDLE, pc 0, instruction 0, imm_data 0, run 0, busy 0, halted 0, timeout_err 0, watchdog 0.

## Timing
- RAM: synchronous write, synchronous read with 1-cycle latency.
- start sampled at edge k → FETCH after edge k, DECODE after k+1, ISSUE (run=1) after k+2.
  - Non-mvi issue latency: 3 cycles.
  - mvi issue latency: 5 cycles.
- done in cycle n → FETCH after edge n. The next run appears 3 cycles after the done edge (5 for mvi).
- Minimum per-instruction throughput when done arrives in ISSUE: 3 cycles (5 for mvi).
- `instruction` updates at the DECODE edge. `imm_data` updates at the IMM_CAP edge.
- `run` and `busy` are Moore outputs decoded from the state register.

## Structure
- Shared package `seq_pkg`:
  - opcode enum: OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_HALT
  - state enum: seq_state_t
  - field-slice localparams for opcode, Rx, Ry
- The control unit imports the same opcode enum.
- One sub-module, `prog_ram`: DEPTH×16, one write port, one synchronous read port.
- The FSM, pc, ir/imm registers and watchdog live in `instr_sequencer`.

## Test plan
- Load [0]=mvi R0 (0x2000), [1]=0x0005, [2]=add R0,R0 (0x4000), [3]=halt (0xE000); start; done 2 cycles after each run → exactly two run pulses: the first with instruction 0x2000 and imm_data 0x0005, the second with 0x4000; then halted=1, busy=0, pc=4.
- done asserted in the same cycle as run for mv (0x0080) followed by halt → next state FETCH; run pulses spaced 3 cycles apart; no WAIT cycles.
- done withheld after an issue with TIMEOUT=16 → timeout_err=1 and halted=1 after 16 WAIT cycles; a subsequent start clears timeout_err and refetches address 0.
- DEPTH=32, mvi at address 31, immediate 0xBEEF written to address 0 → imm_data=0xBEEF and pc wraps to 1.
- load_we pulsed while busy → RAM unchanged, verified by re-running the program; load_we with start in the same IDLE cycle → the new word is issued.
- reset_n dropped during WAIT → run=0, pc=0, busy=0 and state IDLE immediately; stray done pulses after release are ignored.
